// File: rtl/cmp_sweep_pkg.sv
// cmp_sweep_pkg: shared FSM states, sweep sizes and golden comparator masks
package cmp_sweep_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;
  localparam int NUM_VEC = 16;
  localparam int VEC_W = 4;
  localparam logic [15:0] CMP_EXP_F1 = 16'h8CEF;
  localparam logic [15:0] CMP_EXP_F2 = 16'h8421;
endpackage

// File: rtl/cmp_sweep_driver_settle_timer.sv
// settle_timer: clearable up-counter flagging when it reaches a terminal count
module settle_timer
  import cmp_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             en,
  input  logic [VEC_W-1:0] last,
  output logic             tc
);
  logic [VEC_W-1:0] cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign tc = en && cnt == last;
endmodule

// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver: sweeps all 16 vectors through the 2-bit comparator and checks signatures.
// Define CMP_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module cmp_sweep_driver
  import cmp_sweep_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXP_F1        = CMP_EXP_F1,
  parameter logic [15:0] EXP_F2        = CMP_EXP_F2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  output logic [VEC_W-1:0]   vec,
  input  logic               f1_in,
  input  logic               f2_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [NUM_VEC-1:0] sig_f1,
  output logic [NUM_VEC-1:0] sig_f2,
  output logic               fail_valid,
  output logic [VEC_W-1:0]   fail_idx
);
`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif
  localparam logic [VEC_W-1:0] LAST = VEC_W'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);
  // With no settle time the APPLY wait is skipped entirely
  localparam state_t LAUNCH = (SETTLE_CYCLES == 0) ? SAMPLE : APPLY;
  state_t state;
  logic tc, mis, end_sweep;
  assign mis = f1_in != EXP_F1[vec] || f2_in != EXP_F2[vec];
  assign end_sweep = vec == VEC_W'(NUM_VEC - 1) || (STOP_ON_FAIL && mis);
  settle_timer u_timer (
    .clk    (clk),
    .resetn (resetn),
    .clr    (state != APPLY),
    .en     (state == APPLY),
    .last   (LAST),
    .tc     (tc)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      vec        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      sig_f1     <= '0;
      sig_f2     <= '0;
      fail_valid <= 1'b0;
      fail_idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sig_f1     <= '0;
          sig_f2     <= '0;
          pass       <= 1'b0;
          fail_valid <= 1'b0;
          fail_idx   <= '0;
          vec        <= '0;
          busy       <= 1'b1;
          state      <= LAUNCH;
        end
        APPLY: if (tc) state <= SAMPLE;
        SAMPLE: begin
          sig_f1[vec] <= f1_in;
          sig_f2[vec] <= f2_in;
          if (mis && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_idx   <= vec;
          end
          // pass must account for a mismatch on this very last sample
          if (end_sweep) begin
            state <= FINISH;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= !(fail_valid || mis);
          end else begin
            vec   <= vec + 1'b1;
            state <= LAUNCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmp_sweep_driver.sv
// tb_cmp_sweep_driver: scoreboard bench with a fault-injecting comparator model
module tb_cmp_sweep_driver;
  localparam int S = 2;
`ifdef CMP_SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  typedef struct {
    logic [15:0] s1;
    logic [15:0] s2;
    logic        ps;
    logic        fv;
    logic [3:0]  fi;
    logic [3:0]  v;
    int          t;
  } exp_t;

  logic clk = 0, resetn = 0, start = 0, start0 = 0;
  logic [3:0] vec, vec0, fail_idx, fi0;
  logic f1_in, f2_in, f1_0, f2_0;
  logic busy, done, pass, fail_valid, busy0, done0, pass0, fv0;
  logic [15:0] sig_f1, sig_f2, s1_0, s2_0;
  logic [15:0] flip1 = '0, flip2 = '0;
  int cyc = 0, total = 0, bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ideal1(int i);
    return (i / 4) <= (i % 4);
  endfunction
  function automatic logic ideal2(int i);
    return (i / 4) == (i % 4);
  endfunction

  assign f1_in = ideal1(int'(vec)) ^ flip1[vec];
  assign f2_in = ideal2(int'(vec)) ^ flip2[vec];
  assign f1_0  = ideal1(int'(vec0));
  assign f2_0  = ideal2(int'(vec0));

  cmp_sweep_driver #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vec(vec), .f1_in(f1_in), .f2_in(f2_in),
    .busy(busy), .done(done), .pass(pass), .sig_f1(sig_f1), .sig_f2(sig_f2),
    .fail_valid(fail_valid), .fail_idx(fail_idx)
  );
  cmp_sweep_driver #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .resetn(resetn), .start(start0), .vec(vec0), .f1_in(f1_0), .f2_in(f2_0),
    .busy(busy0), .done(done0), .pass(pass0), .sig_f1(s1_0), .sig_f2(s2_0),
    .fail_valid(fv0), .fail_idx(fi0)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  // Expected sweep outcome from the comparator truth table and the injected faults
  function automatic exp_t model(int t);
    exp_t e;
    int n;
    e = '{default: 0};
    n = 16;
    for (int i = 0; i < n; i++) begin
      e.s1[i] = ideal1(i) ^ flip1[i];
      e.s2[i] = ideal2(i) ^ flip2[i];
      if (!e.fv && (flip1[i] || flip2[i])) begin
        e.fv = 1'b1;
        e.fi = 4'(i);
        if (STOP) n = i + 1;
      end
    end
    e.ps = !e.fv;
    e.v  = 4'(n - 1);
    e.t  = t + n * (S + 1) + 1;
    return e;
  endfunction

  task automatic sweep();
    @(negedge clk);
    start = 1;
    q.push_back(model(cyc));
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && done) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done got=1 want=0 at cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("done_time", cyc, e.t);
          chk("busy_at_done", busy, 0);
          chk("sig_f1", sig_f1, e.s1);
          chk("sig_f2", sig_f2, e.s2);
          chk("pass", pass, e.ps);
          chk("fail_valid", fail_valid, e.fv);
          chk("fail_idx", fail_idx, e.fi);
          chk("vec_hold", vec, e.v);
        end
      end
    end
  end

  initial begin
    int p;
    repeat (3) @(negedge clk);
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_sig_f1", sig_f1, 0);
    chk("rst_sig_f2", sig_f2, 0);
    chk("rst_fail_valid", fail_valid, 0);
    chk("rst_fail_idx", fail_idx, 0);
    resetn = 1;
    @(negedge clk);
    start0 = 1;
    p = cyc;
    @(negedge clk);
    start0 = 0;
    for (int k = 0; k < 16; k++) begin
      chk("s0_vec_seq", vec0, k);
      @(negedge clk);
    end
    chk("s0_done", done0, 1);
    chk("s0_latency", cyc - p, 17);
    chk("s0_pass", pass0, 1);
    chk("s0_sig_f1", s1_0, 16'h8CEF);
    chk("s0_sig_f2", s2_0, 16'h8421);
    sweep();
    wait_idle();
    flip1 = 16'h8CEF;
    sweep();
    wait_idle();
    flip1 = '0;
    flip2 = 16'h0400;
    sweep();
    wait_idle();
    for (int r = 0; r < 6; r++) begin
      flip1 = (r % 3 == 0) ? 16'h0 : 16'($urandom) & 16'($urandom) & 16'($urandom);
      flip2 = (r % 2 == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      sweep();
      wait_idle();
    end
    flip1 = '0;
    flip2 = '0;
    sweep();
    repeat (10) @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    wait_idle();
    @(negedge clk);
    start = 1;
    q.push_back(model(cyc));
    q.push_back(model(cyc + 50));
    q.push_back(model(cyc + 100));
    repeat (101) @(negedge clk);
    start = 0;
    wait_idle();
    sweep();
    for (int i = 0; i < 100 && vec != 4'd7; i++) @(negedge clk);
    chk("reach_vec7", vec, 7);
    resetn = 0;
    q.delete();
    #1;
    chk("arst_vec", vec, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sig_f1", sig_f1, 0);
    chk("arst_fail_valid", fail_valid, 0);
    repeat (2) @(negedge clk);
    resetn = 1;
    sweep();
    wait_idle();
    repeat (60) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
